// File: rtl/vga_scan_ctrl_if.sv
// Pixel-request link between vga_scan_ctrl (master) and the one-line pixel buffer (slave).
// The master publishes image coordinates and retire pulses; the buffer answers with a colour byte.
interface vga_scan_ctrl_if;
  logic [7:0] x_coord;
  logic [7:0] y_coord;
  logic       invalidate;
  logic       buf_empty;
  logic [7:0] buf_rgb;

  modport master (output x_coord, y_coord, invalidate, input  buf_empty, buf_rgb);
  modport slave  (input  x_coord, y_coord, invalidate, output buf_empty, buf_rgb);
endinterface

// File: rtl/vga_scan_ctrl.sv
// 640x480@60 VGA scan controller showing a 256x192 buffer doubled into a centred 512x384 window.
// Optional: define VGA_UNDERRUN_DETECT_EN to flag empty-buffer pixels in magenta with a sticky underrun.
module vga_scan_ctrl #(
  parameter int         PIX_DIV      = 4,
  parameter int         H_OFFSET     = 64,
  parameter int         V_OFFSET     = 48,
  parameter logic [7:0] BORDER_COLOR = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_scan_ctrl_if.master buf_if,
  output logic [2:0]      vga_red,
  output logic [2:0]      vga_green,
  output logic [1:0]      vga_blue,
  output logic            vga_hsync,
  output logic            vga_vsync,
  output logic            frame_start,
  output logic            underrun
);

  localparam int              DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd751;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd491;

  localparam logic [9:0] H_IMG_LO = 10'(H_OFFSET);
  localparam logic [9:0] H_IMG_HI = 10'(H_OFFSET + 512);
  localparam logic [9:0] V_IMG_LO = 10'(V_OFFSET);
  localparam logic [9:0] V_IMG_HI = 10'(V_OFFSET + 384);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       h_cnt, v_cnt, h_nxt, v_nxt;
  logic             in_img, in_img_nxt, visible, take_byte;
  logic [7:0]       pix_rgb, rgb_q, x_q, y_q;
  logic             inv_q;

  function automatic logic img_area(input logic [9:0] h, input logic [9:0] v);
    return (h >= H_IMG_LO) && (h < H_IMG_HI) && (v >= V_IMG_LO) && (v < V_IMG_HI);
  endfunction

  assign tick       = (div_cnt == DIV_LAST);
  assign in_img     = img_area(h_cnt, v_cnt);
  assign in_img_nxt = img_area(h_nxt, v_nxt);
  assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // A byte is retired only after its second column copy on the second (odd) row of the pair.
  assign take_byte = tick && in_img && 1'(h_cnt - H_IMG_LO) && 1'(v_cnt - V_IMG_LO)
                     && !buf_if.buf_empty;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  always_comb begin
    pix_rgb = 8'h00;
    if (in_img) begin
`ifdef VGA_UNDERRUN_DETECT_EN
      pix_rgb = buf_if.buf_empty ? 8'hE3 : buf_if.buf_rgb;
`else
      pix_rgb = buf_if.buf_rgb;
`endif
    end else if (visible) begin
      pix_rgb = BORDER_COLOR;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      rgb_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      inv_q       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      inv_q       <= take_byte;
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        h_cnt     <= h_nxt;
        v_cnt     <= v_nxt;
        vga_hsync <= !((h_cnt >= H_SYNC_LO) && (h_cnt <= H_SYNC_HI));
        vga_vsync <= !((v_cnt >= V_SYNC_LO) && (v_cnt <= V_SYNC_HI));
        rgb_q     <= pix_rgb;
        // Coordinates lead the pixel by one tick so the buffer read settles before capture.
        if (in_img_nxt) begin
          x_q <= 8'((h_nxt - H_IMG_LO) >> 1);
          y_q <= 8'((v_nxt - V_IMG_LO) >> 1);
        end
      end
    end
  end

`ifdef VGA_UNDERRUN_DETECT_EN
  logic und_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    und_q <= 1'b0;
    else if (tick && in_img && buf_if.buf_empty)   und_q <= 1'b1;
  end

  assign underrun = und_q;
`else
  assign underrun = 1'b0;
`endif

  assign buf_if.x_coord    = x_q;
  assign buf_if.y_coord    = y_q;
  assign buf_if.invalidate = inv_q;
  assign vga_red           = rgb_q[7:5];
  assign vga_green         = rgb_q[4:2];
  assign vga_blue          = rgb_q[1:0];

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Display-side consumer of the one-line VGA pixel buffer.
- Generates 640x480@60 Hz VGA timing from the system clock using a pixel-enable divider.
- Scales the 256x192 framebuffer 2x in each axis into a centred 512x384 window. Requests pixels from the buffer as (x, y) coordinates and issues single-cycle invalidate pulses in strict raster order.
- Drives the 3:3:2 colour outputs and the active-low sync pins.

Parameters:
- PIX_DIV, 4: system clocks per VGA pixel. Must be >= 2 to cover the 1-clk buffer read latency.
- H_OFFSET, 64: first visible column of the scaled image.
- V_OFFSET, 48: first visible row of the scaled image.
- BORDER_COLOR, 8'h00: colour shown in the visible area outside the image.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- x_coord  out  8  image column currently being displayed
- y_coord  out  8  image row currently being displayed
- invalidate  out  1  one-clk pulse that retires the current buffer byte
- buf_empty  in  1  buffer empty flag
- buf_rgb  in  8  buffer colour byte (RRRGGGBB), valid 1 clk after the previous invalidate
- vga_red  out  3  red output
- vga_green  out  3  green output
- vga_blue  out  2  blue output
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- frame_start  out  1  one-clk pulse on the tick where h=0, v=0
- underrun  out  1  sticky underrun flag (see Optional Feature)

Behaviour:
- Reset: all counters 0; vga_hsync=1, vga_vsync=1, colour outputs 0, invalidate 0, frame_start 0, underrun 0. Asynchronous assert, synchronous-safe deassert. Reset mid-frame restarts scanning at h=0, v=0.
- Divider: div_cnt runs 0..PIX_DIV-1. A tick occurs when div_cnt==PIX_DIV-1. The h/v counters and all display outputs update only on a tick.
- h counter: 0..799, wraps to 0. Visible 0..639. Front porch 640..655. Sync 656..751 (hsync=0). Back porch 752..799.
- v counter: increments when h wraps; 0..524, wraps to 0. Visible 0..479. Front porch 480..489. Sync 490..491 (vsync=0). Back porch 492..524.
- Sync and colour outputs are registered together on the tick, so there is no skew between them.
- in_img = H_OFFSET<=h<H_OFFSET+512 and V_OFFSET<=v<V_OFFSET+384.
- x_coord = (h-H_OFFSET)>>1 and y_coord = (v-V_OFFSET)>>1 when in_img; both hold their last value otherwise.
- Colour on a tick:
  - in_img: captures buf_rgb.
  - visible but not in_img: BORDER_COLOR.
  - blanking: 0.
- Invalidate rule: asserted for exactly one clk, the clk immediately after a tick that captured buf_rgb, when both hold:
  - the column is odd, i.e. (h-H_OFFSET)[0]==1;
  - the row is odd, i.e. (v-V_OFFSET)[0]==1.
- Invalidate consequences:
  - Even display rows re-read the same line without consuming it.
  - Exactly 256 pulses per odd image row, 49152 per frame, never during blanking.
- Invalidate is suppressed while buf_empty=1; the byte is retained and the pixel is still displayed.
- frame_start is independent of invalidate.
- Width: counters are 10 bits. Coordinate arithmetic is 10-bit, truncated to 8 after the shift.

Optional Feature:
- Macro: VGA_UNDERRUN_DETECT_EN.
- Defined:
  - If buf_empty=1 on an in_img tick, the colour output is 8'hE3 (magenta) instead of buf_rgb.
  - underrun sets and stays 1 until rst_n is asserted.
  - Invalidate suppression is unchanged.
- Undefined: buf_rgb is displayed regardless of buf_empty, and underrun is tied to 0.

Test Plan:
- PIX_DIV=4, free run -> hsync low for 384 clks every 3200 clks. vsync low for 2 lines every 525 lines. frame_start period 1,680,000 clks.
- Count invalidates over one frame with buf_empty=0 -> exactly 49152. First pulse at v=49, h=65. None on v=48 or during blanking.
- Buffer model returning byte index as colour -> pixel at h=64,v=48 equals h=65,v=49 equals byte 0. h=66 shows byte 1. Row v=50 shows byte 256.
- Visible pixel h=10, v=10 with BORDER_COLOR=8'h1C -> vga_green=3'b111, red=0, blue=0. h=700 -> all colour outputs 0.
- buf_empty=1 at v=49, h=65 -> no invalidate pulse. With VGA_UNDERRUN_DETECT_EN: colour 8'hE3 and underrun=1 sticky. Without: underrun stays 0.
- Assert rst_n=0 at mid-frame (v=200) for 3 clks -> outputs at reset values immediately. After release, frame_start occurs after 1 tick and invalidate count restarts from 0.
